// File: rtl/logic_shift_unit_pkg.sv
// Funct codes, FSM states and op classes shared by logic_shift_unit; no latency, no flow control.
// LOGIC_SHIFT_UNIT_SRA_EN decides whether SRA/SRAV classify as arithmetic shifts or as illegal.
package logic_shift_pkg;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    LOGIC   = 3'd0,
    SHL     = 3'd1,
    SHR     = 3'd2,
    SHA     = 3'd3,
    ILLEGAL = 3'd4
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] f);
    op_class_t c;
    case (f)
      F_AND, F_OR, F_XOR, F_NOR: c = LOGIC;
      F_SLL, F_SLLV:             c = SHL;
      F_SRL, F_SRLV:             c = SHR;
`ifdef LOGIC_SHIFT_UNIT_SRA_EN
      F_SRA, F_SRAV:             c = SHA;
`endif
      default:                   c = ILLEGAL;
    endcase
    return c;
  endfunction

  // Variable shifts take their amount from rs instead of the immediate field.
  function automatic logic is_variable(input logic [5:0] f);
    return (f == F_SLLV) || (f == F_SRLV) || (f == F_SRAV);
  endfunction

endpackage

// File: rtl/logic_shift_unit_step_shifter.sv
// Combinational single-step shifter (amount 0..STEP); zero latency, no flow control.
// dir=0 shifts left with zero fill, dir=1 shifts right filling vacated bits with fill.
module lsu_step_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic             fill,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    fill_mask = fill ? ~({WIDTH{1'b1}} >> amount) : '0;
    result    = dir ? ((value >> amount) | fill_mask) : (value << amount);
  end

endmodule

// File: rtl/logic_shift_unit.sv
// MIPS logic/shift unit: logic ops 1 cycle, shifts ceil(n/STEP) cycles; one op in flight, in_ready only in IDLE.
// Result holds in DONE until out_ready; SRA/SRAV exist only with LOGIC_SHIFT_UNIT_SRA_EN defined.
module logic_shift_unit
  import logic_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SAW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SAW-1:0]   sa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             illegal
);

  localparam int AW = $clog2(STEP) + 1;
  localparam logic [SAW-1:0] STEP_S = SAW'(STEP);

  state_t           state;
  op_class_t        cls_q;
  logic [SAW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic             ill_q;
`ifdef LOGIC_SHIFT_UNIT_SRA_EN
  logic             sign_q;
`endif

  op_class_t        cls_in;
  logic [SAW-1:0]   amt_in;
  logic [WIDTH-1:0] logic_res;
  op_class_t        sh_cls;
  logic [SAW-1:0]   sh_rem;
  logic [WIDTH-1:0] sh_val;
  logic [AW-1:0]    sh_amt;
  logic [SAW-1:0]   rem_next;
  logic             sh_dir;
  logic             sh_fill;
  logic [WIDTH-1:0] sh_out;

  assign cls_in = op_class(op);
  assign amt_in = is_variable(op) ? a[SAW-1:0] : sa;

  always_comb begin
    logic_res = '0;
    case (op[1:0])
      2'b00: logic_res = a & b;
      2'b01: logic_res = a | b;
      2'b10: logic_res = a ^ b;
      2'b11: logic_res = ~(a | b);
      default: logic_res = '0;
    endcase
  end

  // The first step is taken on the accept edge straight from b, later steps from acc.
  always_comb begin
    sh_cls = cls_q;
    sh_rem = cnt;
    sh_val = acc;
    if (state == IDLE) begin
      sh_cls = cls_in;
      sh_rem = amt_in;
      sh_val = b;
    end
  end

  assign sh_amt   = (sh_rem > STEP_S) ? AW'(STEP) : sh_rem[AW-1:0];
  assign rem_next = sh_rem - SAW'(sh_amt);
  assign sh_dir   = (sh_cls != SHL);

`ifdef LOGIC_SHIFT_UNIT_SRA_EN
  assign sh_fill = (sh_cls == SHA) && ((state == IDLE) ? b[WIDTH-1] : sign_q);
`else
  assign sh_fill = 1'b0;
`endif

  lsu_step_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value  (sh_val),
    .dir    (sh_dir),
    .fill   (sh_fill),
    .amount (sh_amt),
    .result (sh_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cls_q  <= LOGIC;
      cnt    <= '0;
      acc    <= '0;
      ill_q  <= 1'b0;
`ifdef LOGIC_SHIFT_UNIT_SRA_EN
      sign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cls_q  <= cls_in;
            ill_q  <= (cls_in == ILLEGAL);
`ifdef LOGIC_SHIFT_UNIT_SRA_EN
            sign_q <= b[WIDTH-1];
`endif
            case (cls_in)
              LOGIC: begin
                acc   <= logic_res;
                cnt   <= '0;
                state <= DONE;
              end
              ILLEGAL: begin
                acc   <= '0;
                cnt   <= '0;
                state <= DONE;
              end
              default: begin
                acc   <= sh_out;
                cnt   <= rem_next;
                state <= (rem_next == '0) ? DONE : BUSY;
              end
            endcase
          end
        end
        BUSY: begin
          acc <= sh_out;
          cnt <= rem_next;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign r         = acc;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed bench for logic_shift_unit: one STEP=1 and one STEP=4 instance sharing operand inputs.
// Expectations are hand-computed; SRA results follow LOGIC_SHIFT_UNIT_SRA_EN.
module tb_logic_shift_unit;
  import logic_shift_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [5:0]  op;
  logic [31:0] a, b;
  logic [4:0]  sa;
  logic        iv1, ir1, ov1, or1, il1;
  logic        iv4, ir4, ov4, or4, il4;
  logic [31:0] r1, r4;

  int          sel;
  logic        ov_s, ir_s, il_s;
  logic [31:0] r_s;
  int          n_checks;
  int          n_fail;

  logic_shift_unit #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b),
    .sa(sa), .out_valid(ov1), .out_ready(or1), .r(r1), .illegal(il1)
  );

  logic_shift_unit #(.WIDTH(32), .STEP(4)) u4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4), .op(op), .a(a), .b(b),
    .sa(sa), .out_valid(ov4), .out_ready(or4), .r(r4), .illegal(il4)
  );

  assign ov_s = (sel == 1) ? ov4 : ov1;
  assign ir_s = (sel == 1) ? ir4 : ir1;
  assign il_s = (sel == 1) ? il4 : il1;
  assign r_s  = (sel == 1) ? r4  : r1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and waits (bounded) for out_valid; lat counts negedges after accept.
  task automatic run_op(input int s, input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] sav, output int lat, output logic leak);
    @(negedge clk);
    sel = s; op = f; a = av; b = bv; sa = sav;
    if (s == 1) iv4 = 1'b1; else iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; iv4 = 1'b0;
    lat = 1; leak = 1'b0;
    while (!ov_s && lat < 64) begin
      if (ir_s) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    if (sel == 1) or4 = 1'b1; else or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0; or4 = 1'b0;
  endtask

  task automatic do_op(input string tag, input int s, input logic [5:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] sav, input logic [31:0] er,
                       input logic eill, input int elat);
    int   lat;
    logic leak;
    run_op(s, f, av, bv, sav, lat, leak);
    check({tag, "_r"}, r_s, er);
    check({tag, "_ill"}, 32'(il_s), 32'(eill));
    check({tag, "_lat"}, lat, elat);
    check({tag, "_rdy_busy"}, 32'(leak), 32'd0);
    release_out();
  endtask

  initial begin
    int   lat;
    logic leak;
    n_checks = 0; n_fail = 0; sel = 0;
    reset_n = 1'b0; op = '0; a = '0; b = '0; sa = '0;
    iv1 = 1'b0; iv4 = 1'b0; or1 = 1'b0; or4 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(ir1), 32'd1);
    check("rst_vld", 32'(ov1), 32'd0);
    check("rst_r", r1, 32'd0);
    check("rst_ill", 32'(il1), 32'd0);
    check("rst_rdy4", 32'(ir4), 32'd1);

    do_op("and",   0, F_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1);
    do_op("or",    0, F_OR,  32'h0F0F0000, 32'h000000FF, 5'd0, 32'h0F0F00FF, 1'b0, 1);
    do_op("nor",   0, F_NOR, 32'h0000FFFF, 32'h00FF0000, 5'd0, 32'hFF000000, 1'b0, 1);
    do_op("sll4",  0, F_SLL, 32'h0,        32'h00000001, 5'd4, 32'h00000010, 1'b0, 4);
    do_op("sll0",  0, F_SLL, 32'h0,        32'h12345678, 5'd0, 32'h12345678, 1'b0, 1);
    do_op("srl1",  0, F_SRL, 32'h0,        32'h80000000, 5'd1, 32'h40000000, 1'b0, 1);
`ifdef LOGIC_SHIFT_UNIT_SRA_EN
    do_op("srav",  0, F_SRAV, 32'h00000024, 32'h80000000, 5'd0, 32'hF8000000, 1'b0, 4);
`else
    do_op("srav",  0, F_SRAV, 32'h00000024, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1);
`endif
    do_op("srl31_s4", 1, F_SRL,  32'h0,        32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b0, 8);
    do_op("sllv_s4",  1, F_SLLV, 32'h00000005, 32'h00000003, 5'd0,  32'h00000060, 1'b0, 2);

    // Result must hold in DONE while in_valid is pulsed and out_ready stays low.
    run_op(0, F_XOR, 32'h0000FFFF, 32'h12345678, 5'd0, lat, leak);
    check("hold_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin op = F_AND; a = '0; b = '0; iv1 = 1'b1; end
      if (i == 2) iv1 = 1'b0;
      @(negedge clk);
      check("hold_r", r1, 32'h1234A987);
      check("hold_vld", 32'(ov1), 32'd1);
    end
    release_out();
    check("hold_idle_rdy", 32'(ir1), 32'd1);
    check("hold_idle_vld", 32'(ov1), 32'd0);
    @(negedge clk);
    check("hold_idle_r", r1, 32'h1234A987);
    check("hold_noacc_vld", 32'(ov1), 32'd0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    sel = 0; op = F_SRL; a = '0; b = 32'hFFFFFFFF; sa = 5'd31; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_rdy", 32'(ir1), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(ov1), 32'd0);
    check("mid_rst_r", r1, 32'd0);
    check("mid_rst_ill", 32'(il1), 32'd0);
    check("mid_rst_r4", r4, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(ir1), 32'd1);
    do_op("xor", 0, F_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555, 1'b0, 1);
    do_op("ill", 0, 6'b101010, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h00000000, 1'b1, 1);
    do_op("ill_s4", 1, 6'b111111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
